mux_scan_n: RTL and testbench

// Parametrised N-channel, W-bit registered multiplexer with a decoded one-hot select.

---
 rtl/mux_scan_n.sv | 94 +++++++++
 tb/tb_mux_scan_n.sv | 105 ++++++++++
 2 files changed

// File: rtl/mux_scan_n.sv
// rtl/mux_scan_n.sv - N-channel registered mux with manual select and round-robin auto-scan
module mux_scan_n #(
    parameter int N = 4,
    parameter int W = 1,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  i,
    input  logic [SW-1:0]   s,
    input  logic            mode,
    input  logic [N-1:0]    en,
    input  logic            out_ready,
    output logic [W-1:0]    z,
    output logic            z_valid,
    output logic [SW-1:0]   sel_q,
    output logic [N-1:0]    sel_oh
);
    typedef enum logic {ST_MAN = 1'b0, ST_SCAN = 1'b1} state_t;

    state_t        r_state;
    logic [SW-1:0] r_ptr;
    logic [W-1:0]  r_z;
    logic          r_valid;
    logic [SW-1:0] r_sel;
    logic [N-1:0]  r_oh;

    logic          w_load;
    logic [SW-1:0] w_base;
    logic [SW-1:0] w_idx;
    logic [SW-1:0] w_scan;
    logic          w_found;
    logic [SW-1:0] w_c;
    logic          w_hit;
    logic [W-1:0]  w_data;
    logic [N-1:0]  w_oh;

    assign w_load = !r_valid || out_ready;

    // Entering SCAN from MAN seeds the pointer one below s so the scan starts at s.
    assign w_base = (r_state == ST_SCAN) ? r_ptr : (s - SW'(1));

    // Walk from farthest to nearest so the nearest enabled channel after w_base wins;
    // k=N wraps to w_base itself, which is therefore checked last.
    always_comb begin
        w_found = 1'b0;
        w_scan  = w_base;
        w_idx   = w_base;
        for (int k = N; k >= 1; k--) begin
            w_idx = w_base + SW'(k);
            if (en[w_idx]) begin
                w_found = 1'b1;
                w_scan  = w_idx;
            end
        end
    end

    assign w_c    = mode ? w_scan : s;
    assign w_hit  = mode ? w_found : en[s];
    assign w_data = i[w_c*W +: W];
    assign w_oh   = N'(1) << w_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_MAN;
            r_ptr   <= SW'(N - 1);
            r_z     <= {W{1'b1}};
            r_valid <= 1'b0;
            r_sel   <= '0;
            r_oh    <= '0;
        end else if (w_load) begin
            r_state <= mode ? ST_SCAN : ST_MAN;
            if (w_hit) begin
                r_z     <= w_data;
                r_valid <= 1'b1;
                r_sel   <= w_c;
                r_oh    <= w_oh;
                r_ptr   <= w_c;
            end else begin
                r_z     <= {W{1'b1}};
                r_valid <= 1'b0;
                r_oh    <= '0;
                if (mode) begin
                    r_ptr <= w_base;
                end
            end
        end
    end

    assign z       = r_z;
    assign z_valid = r_valid;
    assign sel_q   = r_sel;
    assign sel_oh  = r_oh;
endmodule

// File: tb/tb_mux_scan_n.sv
// tb/tb_mux_scan_n.sv - directed self-checking bench for mux_scan_n (N=4, W=4)
module tb_mux_scan_n;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*W-1:0]  i;
    logic [SW-1:0]   s;
    logic            mode;
    logic [N-1:0]    en;
    logic            out_ready;
    logic [W-1:0]    z;
    logic            z_valid;
    logic [SW-1:0]   sel_q;
    logic [N-1:0]    sel_oh;

    int n_checks = 0;
    int n_errors = 0;

    mux_scan_n #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .i(i), .s(s), .mode(mode), .en(en),
        .out_ready(out_ready), .z(z), .z_valid(z_valid), .sel_q(sel_q), .sel_oh(sel_oh)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] ez, input logic ev,
                             input logic [1:0] es, input logic [3:0] eoh);
        check({tag, ".z"},       {12'h0, z},      {12'h0, ez});
        check({tag, ".z_valid"}, {15'h0, z_valid}, {15'h0, ev});
        check({tag, ".sel_q"},   {14'h0, sel_q},  {14'h0, es});
        check({tag, ".sel_oh"},  {12'h0, sel_oh}, {12'h0, eoh});
    endtask

    initial begin
        i = 16'hDCBA; s = '0; mode = 1'b0; en = 4'hF; out_ready = 1'b0;

        // 1: reset
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        check_out("reset", 4'hF, 1'b0, 2'd0, 4'b0000);

        // 2: manual pick of channel 2
        mode = 1'b0; s = 2'd2; en = 4'hF; out_ready = 1'b1;
        tick(); check_out("man_s2", 4'hC, 1'b1, 2'd2, 4'b0100);

        // 3: auto-scan from reset over en=1011
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 1'b1; s = 2'd0; en = 4'b1011; out_ready = 1'b1;
        tick(); check_out("scan0", 4'hA, 1'b1, 2'd0, 4'b0001);
        tick(); check_out("scan1", 4'hB, 1'b1, 2'd1, 4'b0010);
        tick(); check_out("scan2", 4'hD, 1'b1, 2'd3, 4'b1000);
        tick(); check_out("scan3", 4'hA, 1'b1, 2'd0, 4'b0001);
        tick(); check_out("scan4", 4'hB, 1'b1, 2'd1, 4'b0010);

        // 4: backpressure holds B, inputs ignored while stalled
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) i = 16'h1234;
            tick(); check_out("stall", 4'hB, 1'b1, 2'd1, 4'b0010);
        end
        i = 16'hDCBA; out_ready = 1'b1;
        tick(); check_out("resume0", 4'hD, 1'b1, 2'd3, 4'b1000);
        tick(); check_out("resume1", 4'hA, 1'b1, 2'd0, 4'b0001);

        // 5a: all channels disabled in SCAN
        en = 4'b0000;
        tick(); check_out("scan_none", 4'hF, 1'b0, 2'd0, 4'b0000);

        // 5b: MAN with en[s]=0 after a valid word; sel_q holds
        mode = 1'b0; en = 4'b1011; s = 2'd1;
        tick(); check_out("man_s1", 4'hB, 1'b1, 2'd1, 4'b0010);
        s = 2'd2;
        tick(); check_out("man_off", 4'hF, 1'b0, 2'd1, 4'b0000);

        // 6: reset mid-scan under backpressure, then restart at channel 0
        mode = 1'b1; s = 2'd0; en = 4'hF; out_ready = 1'b1;
        tick(); check_out("pre_rst0", 4'hA, 1'b1, 2'd0, 4'b0001);
        tick(); check_out("pre_rst1", 4'hB, 1'b1, 2'd1, 4'b0010);
        out_ready = 1'b0; rst = 1'b1;
        tick(); check_out("rst_mid", 4'hF, 1'b0, 2'd0, 4'b0000);
        rst = 1'b0;
        tick(); check_out("restart0", 4'hA, 1'b1, 2'd0, 4'b0001);
        tick(); check_out("restart_hold", 4'hA, 1'b1, 2'd0, 4'b0001);
        out_ready = 1'b1;
        tick(); check_out("restart1", 4'hB, 1'b1, 2'd1, 4'b0010);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
